// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 miss-fill controller.
//   fill_state_t    : controller state (IDLE waits for a miss, FILL fetches a block)
//   BLOCK_BYTES     : bytes per cache block
//   WORD_BYTES      : byte stride between consecutive words
//   WORDS_PER_BLOCK : words fetched per miss (power of 2)
//   OFFSET_BITS     : byte-offset bits inside a block
//   CNT_W           : word-counter width, one extra bit so the count can reach WORDS_PER_BLOCK
package cache_pkg;

  typedef enum logic [0:0] {
    IDLE,
    FILL
  } fill_state_t;

  localparam int unsigned BLOCK_BYTES     = 16;
  localparam int unsigned WORD_BYTES      = 2;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned OFFSET_BITS     = $clog2(BLOCK_BYTES);
  localparam int unsigned CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;

endpackage

// File: rtl/fill_word_counter.sv
// Saturating word counter used for both the issue and return sides of a fill.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears the count
//   i_clr   : synchronous clear (takes priority over i_en)
//   i_en    : count up by one unless already at MAX_COUNT
//   o_count : current count
//   o_done  : count has reached MAX_COUNT
module fill_word_counter #(
  parameter int unsigned MAX_COUNT = cache_pkg::WORDS_PER_BLOCK,
  parameter int unsigned CNT_W     = cache_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller between one L1 cache and the pipelined main memory.
// On a miss it reads every word of the block, writes each returned word into the
// data array as it arrives, and pulses the tag write together with the last word.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   miss_detected      : cache lookup missed this cycle
//   miss_address       : byte address of the missing access (offset ignored)
//   fsm_busy           : fill in progress, stalls the pipeline
//   memory_address     : read address to main memory
//   mem_read_en        : issue a memory read this cycle
//   memory_data_valid  : memory returns one word this cycle
//   memory_data_in     : returned word
//   write_data_array   : write cache_data_out at cache_word_addr
//   cache_word_addr    : byte address of the word being written
//   cache_data_out     : word to write (pass-through of memory_data_in)
//   write_tag_array    : one-cycle tag write / valid set for the block
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int unsigned WORD_BYTES      = cache_pkg::WORD_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  mem_read_en,
  input  logic                  memory_data_valid,
  input  logic [DATA_WIDTH-1:0] memory_data_in,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] cache_word_addr,
  output logic [DATA_WIDTH-1:0] cache_data_out,
  output logic                  write_tag_array
);

  localparam int unsigned CntW = $clog2(WORDS_PER_BLOCK) + 1;
  localparam logic [ADDR_WIDTH-1:0] OffsetMask = ADDR_WIDTH'(WORDS_PER_BLOCK * WORD_BYTES - 1);

  fill_state_t           r_state;
  fill_state_t           w_state_d;
  logic [ADDR_WIDTH-1:0] r_base;

  logic                  w_start;
  logic                  w_issue_en;
  logic                  w_issue_done;
  logic [CntW-1:0]       w_issue_cnt;
  logic                  w_ret_en;
  logic [CntW-1:0]       w_ret_cnt;
  logic                  w_unused_ret_done;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [ADDR_WIDTH-1:0] w_ret_addr;

  // Counters are cleared on the miss cycle so FILL always starts at word 0.
  assign w_start    = (r_state == IDLE) && miss_detected;
  assign w_issue_en = (r_state == FILL) && !w_issue_done;
  assign w_ret_en   = (r_state == FILL) && memory_data_valid;
  assign w_last     = w_ret_en && (w_ret_cnt == CntW'(WORDS_PER_BLOCK - 1));

  assign w_issue_addr = r_base + (ADDR_WIDTH'(w_issue_cnt) * ADDR_WIDTH'(WORD_BYTES));
  assign w_ret_addr   = r_base + (ADDR_WIDTH'(w_ret_cnt) * ADDR_WIDTH'(WORD_BYTES));

  fill_word_counter #(
    .MAX_COUNT (WORDS_PER_BLOCK),
    .CNT_W     (CntW)
  ) u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_en    (w_issue_en),
    .o_count (w_issue_cnt),
    .o_done  (w_issue_done)
  );

  fill_word_counter #(
    .MAX_COUNT (WORDS_PER_BLOCK),
    .CNT_W     (CntW)
  ) u_ret_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_en    (w_ret_en),
    .o_count (w_ret_cnt),
    .o_done  (w_unused_ret_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_base <= miss_address & ~OffsetMask;
      end
    end
  end

  always_comb begin
    w_state_d        = r_state;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_word_addr  = '0;
    write_tag_array  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Combinational so the stall also covers the miss cycle itself.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          w_state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (w_issue_en) begin
          mem_read_en    = 1'b1;
          memory_address = w_issue_addr;
        end
        if (w_ret_en) begin
          write_data_array = 1'b1;
          cache_word_addr  = w_ret_addr;
        end
        // Tag is written alongside the final data word, never earlier.
        if (w_last) begin
          write_tag_array = 1'b1;
          w_state_d       = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign cache_data_out = memory_data_in;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed self-checking bench for cache_fill_fsm with a 4-cycle pipelined memory model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        fsm_busy;
  logic [15:0] memory_address;
  logic        mem_read_en;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        write_data_array;
  logic [15:0] cache_word_addr;
  logic [15:0] cache_data_out;
  logic        write_tag_array;

  // Memory model: auto mode returns data == address 4 cycles after issue;
  // manual mode lets a test drive returns directly.
  logic        mem_auto = 1'b1;
  logic        man_valid = 1'b0;
  logic [15:0] man_data = 16'h0;
  logic [3:0]  pipe_v;
  logic [15:0] pipe_a [4];

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int tag_cnt = 0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_address    (memory_address),
    .mem_read_en       (mem_read_en),
    .memory_data_valid (memory_data_valid),
    .memory_data_in    (memory_data_in),
    .write_data_array  (write_data_array),
    .cache_word_addr   (cache_word_addr),
    .cache_data_out    (cache_data_out),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < 4; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[2:0], mem_read_en};
      pipe_a[0] <= memory_address;
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
      pipe_a[3] <= pipe_a[2];
    end
  end

  assign memory_data_valid = mem_auto ? pipe_v[3] : man_valid;
  assign memory_data_in    = mem_auto ? pipe_a[3] : man_data;

  always @(posedge clk) begin
    if (write_data_array) wr_cnt <= wr_cnt + 1;
    if (write_tag_array) tag_cnt <= tag_cnt + 1;
  end

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address,
         cache_word_addr, cache_data_out} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_held: busy=%b rd=%b wr=%b tag=%b ma=%h wa=%h wd=%h, want all 0",
               fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address,
               cache_word_addr, cache_data_out);
    end
    @(posedge clk); #1 rst = 1'b0;
    // Mid-cycle reset pulse with no miss pending.
    @(negedge clk); rst = 1'b1;
    #1;
    n_tests++;
    if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_pulse: busy=%b rd=%b wr=%b tag=%b, want 0000",
               fsm_busy, mem_read_en, write_data_array, write_tag_array);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if ({fsm_busy, mem_read_en} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d: busy=%b rd=%b, want 0 0", c, fsm_busy, mem_read_en);
      end
      @(posedge clk); #1;
    end
  endtask

  // Drives a miss at cycle 0 and checks cycles 0..12 against the 4-cycle latency
  // timeline. chain leaves the next cycle free for a back-to-back miss.
  task automatic run_fill(input logic [15:0] addr, input bit spur, input bit chain,
                          input string name);
    logic [15:0] base;
    logic        exp_rd, exp_wr, exp_tag;
    logic [15:0] exp_ma, exp_wa, obs_ma, obs_wa, obs_wd;
    base = addr & 16'hFFF0;
    for (int c = 0; c <= 12; c++) begin
      miss_detected = (c == 0) || (spur && c >= 2 && c <= 6);
      miss_address  = (c == 0) ? addr : 16'h5552;
      @(negedge clk);
      exp_rd  = (c >= 1 && c <= 8);
      exp_wr  = (c >= 5);
      exp_tag = (c == 12);
      exp_ma  = exp_rd ? base + 16'(2 * (c - 1)) : 16'h0;
      exp_wa  = exp_wr ? base + 16'(2 * (c - 5)) : 16'h0;
      obs_ma  = exp_rd ? memory_address : 16'h0;
      obs_wa  = exp_wr ? cache_word_addr : 16'h0;
      obs_wd  = exp_wr ? cache_data_out : 16'h0;
      n_tests++;
      if ({fsm_busy, mem_read_en, write_data_array, write_tag_array, obs_ma, obs_wa, obs_wd}
          !== {1'b1, exp_rd, exp_wr, exp_tag, exp_ma, exp_wa, exp_wa}) begin
        n_fail++;
        $display("FAIL %s cycle %0d: busy=%b rd=%b ma=%h wr=%b wa=%h wd=%h tag=%b, want 1 %b %h %b %h %h %b",
                 name, c, fsm_busy, mem_read_en, obs_ma, write_data_array, obs_wa, obs_wd,
                 write_tag_array, exp_rd, exp_ma, exp_wr, exp_wa, exp_wa, exp_tag);
      end
      @(posedge clk); #1;
    end
    miss_detected = 1'b0;
    if (!chain) begin
      @(negedge clk);
      n_tests++;
      if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0) begin
        n_fail++;
        $display("FAIL %s cycle 13: busy=%b rd=%b wr=%b tag=%b, want 0000", name, fsm_busy,
                 mem_read_en, write_data_array, write_tag_array);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_miss();
    run_fill(16'h1236, 1'b0, 1'b0, "single_miss");
  endtask

  task automatic test_stalled_memory();
    logic [15:0] base;
    int w0, t0;
    base = 16'h2460;
    w0 = wr_cnt;
    t0 = tag_cnt;
    mem_auto  = 1'b0;
    man_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      miss_detected = (c == 0);
      miss_address  = 16'h2468;
      @(negedge clk);
      n_tests++;
      if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !==
          {1'b1, (c >= 1 && c <= 8), 2'b00} ||
          (c >= 1 && c <= 8 && memory_address !== base + 16'(2 * (c - 1)))) begin
        n_fail++;
        $display("FAIL stall_issue cycle %0d: busy=%b rd=%b ma=%h wr=%b tag=%b", c, fsm_busy,
                 mem_read_en, memory_address, write_data_array, write_tag_array);
      end
      @(posedge clk); #1;
    end
    miss_detected = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < 3; g++) begin
        man_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({fsm_busy, write_data_array, write_tag_array} !== 3'b100) begin
          n_fail++;
          $display("FAIL stall_gap word %0d: busy=%b wr=%b tag=%b, want 1 0 0", k, fsm_busy,
                   write_data_array, write_tag_array);
        end
        @(posedge clk); #1;
      end
      man_valid = 1'b1;
      man_data  = 16'hA000 + 16'(k);
      @(negedge clk);
      n_tests++;
      if ({fsm_busy, write_data_array, write_tag_array, cache_word_addr, cache_data_out} !==
          {2'b11, (k == 7), base + 16'(2 * k), 16'hA000 + 16'(k)}) begin
        n_fail++;
        $display("FAIL stall_write word %0d: busy=%b wr=%b tag=%b wa=%h wd=%h, want 1 1 %b %h %h",
                 k, fsm_busy, write_data_array, write_tag_array, cache_word_addr, cache_data_out,
                 (k == 7), base + 16'(2 * k), 16'hA000 + 16'(k));
      end
      @(posedge clk); #1;
    end
    man_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({fsm_busy, write_data_array, write_tag_array} !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_done: busy=%b wr=%b tag=%b, want 0 0 0", fsm_busy, write_data_array,
               write_tag_array);
    end
    n_tests++;
    if (wr_cnt - w0 != 8 || tag_cnt - t0 != 1) begin
      n_fail++;
      $display("FAIL stall_counts: writes=%0d tags=%0d, want 8 1", wr_cnt - w0, tag_cnt - t0);
    end
    @(posedge clk); #1;
    mem_auto = 1'b1;
  endtask

  task automatic test_spurious();
    mem_auto  = 1'b0;
    man_valid = 1'b1;
    man_data  = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({fsm_busy, write_data_array, write_tag_array} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_valid cycle %0d: busy=%b wr=%b tag=%b, want 0 0 0", c, fsm_busy,
                 write_data_array, write_tag_array);
      end
      @(posedge clk); #1;
    end
    man_valid = 1'b0;
    mem_auto  = 1'b1;
    run_fill(16'h3016, 1'b1, 1'b0, "repeat_miss");
  endtask

  task automatic test_reset_mid_fill();
    int t0;
    t0 = tag_cnt;
    for (int c = 0; c < 7; c++) begin
      miss_detected = (c == 0);
      miss_address  = 16'hFFF8;
      @(posedge clk); #1;
    end
    miss_detected = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address,
         cache_word_addr, cache_data_out} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b rd=%b wr=%b tag=%b ma=%h wa=%h wd=%h, want all 0",
               fsm_busy, mem_read_en, write_data_array, write_tag_array, memory_address,
               cache_word_addr, cache_data_out);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fsm_busy !== 1'b0 || tag_cnt != t0) begin
      n_fail++;
      $display("FAIL reset_no_tag: busy=%b tags=%0d, want 0 0", fsm_busy, tag_cnt - t0);
    end
    @(posedge clk); #1;
    run_fill(16'hFFF0, 1'b0, 1'b0, "top_block");
  endtask

  task automatic test_back_to_back();
    int w0, t0;
    w0 = wr_cnt;
    t0 = tag_cnt;
    run_fill(16'h0000, 1'b0, 1'b1, "b2b_first");
    run_fill(16'h0040, 1'b0, 1'b0, "b2b_second");
    n_tests++;
    if (wr_cnt - w0 != 16 || tag_cnt - t0 != 2) begin
      n_fail++;
      $display("FAIL b2b_counts: writes=%0d tags=%0d, want 16 2", wr_cnt - w0, tag_cnt - t0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_miss();
    test_stalled_memory();
    test_spurious();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
